video_sig_gen: RTL
==================

Name: video_sig_gen

Overview:
- Raster timing generator for the HDMI output path; sits directly upstream of the test pattern generator and the TMDS encoders.
- Produces pixel coordinates (hcount/vcount), active-region flag, hsync/vsync, a one-cycle new-frame strobe and a frame counter.
- Runs on the pixel clock; default timing is 1280x720p60 (74.25 MHz).

Parameters:
- ACTIVE_H, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- ACTIVE_V, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- FC_WIDTH, 6, frame counter width
- Derived (localparam): H_TOTAL=ACTIVE_H+H_FP+H_SYNC+H_BP (1650); V_TOTAL=ACTIVE_V+V_FP+V_SYNC+V_BP (750); HW=$clog2(H_TOTAL); VW=$clog2(V_TOTAL)

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- o_hcount  out  HW  horizontal position, 0..H_TOTAL-1
- o_vcount  out  VW  vertical position, 0..V_TOTAL-1
- o_hsync  out  1  horizontal sync, active high
- o_vsync  out  1  vertical sync, active high
- o_active_draw  out  1  high when position is inside the active region
- o_new_frame  out  1  one-cycle strobe at the start of vertical blanking
- o_frame_count  out  FC_WIDTH  frame counter

Behaviour:
- Reset (i_rst_n low, asynchronous): all outputs 0, including o_active_draw; internal started flag cleared.
- All outputs registered; in every cycle all outputs describe the same (o_hcount, o_vcount) position. No relative skew is allowed.
- First rising edge with i_rst_n high: outputs load position (0,0) with o_active_draw=1; started flag set. Each later edge advances the position by one pixel.
- Horizontal: o_hcount increments by 1; at H_TOTAL-1 it wraps to 0 and o_vcount advances.
- Vertical: o_vcount increments only on horizontal wrap; at V_TOTAL-1 together with hcount H_TOTAL-1, both wrap to 0.
- o_active_draw = (hcount < ACTIVE_H) && (vcount < ACTIVE_V).
- o_hsync = 1 iff ACTIVE_H+H_FP <= hcount < ACTIVE_H+H_FP+H_SYNC (default 1390..1429). The test is independent of vcount.
- o_vsync = 1 iff ACTIVE_V+V_FP <= vcount < ACTIVE_V+V_FP+V_SYNC (default 725..729), for the whole line including horizontal blanking.
- o_new_frame = 1 for exactly the one cycle where hcount==ACTIVE_H and vcount==ACTIVE_V. It fires once per frame.
- o_frame_count increments in the same cycle o_new_frame is asserted and wraps from 2^FC_WIDTH-1 to 0. The first frame after reset reads 0 during its active region.
- Reset asserted mid-frame: outputs clear immediately. After release, the sequence restarts at (0,0) exactly as after power-on, with no partial strobe.
- Counters never exceed their totals; any out-of-range state recovers to 0 on the next edge.

Decomposition:
- Package video_timing_pkg holds the 720p default constants (ACTIVE_H, H_FP, H_SYNC, H_BP, ACTIVE_V, V_FP, V_SYNC, V_BP, H_TOTAL, V_TOTAL), so pattern and encode stages share them.
- One natural sub-module: wrap_counter (parameter MAX, inputs i_clk/i_rst_n/i_inc, outputs o_count/o_wrap). Instantiate it twice, for h and v; the h o_wrap drives the v i_inc.

Test Plan:
- Hold i_rst_n low 5 cycles, then release -> every output is 0 during reset; first edge after release gives hcount=0, vcount=0, active_draw=1, hsync=0, vsync=0.
- Run to hcount=1279, vcount=0 -> active_draw=1. Next cycle hcount=1280, active_draw=0; hsync rises at hcount=1390, falls at 1430; hcount 1649 -> 0 with vcount -> 1.
- Run to vcount=724 -> vsync=0. vcount=725..729 -> vsync=1 across all hcount values; vcount=730 -> vsync=0.
- Full frame -> new_frame high exactly once at (1280,720); frame_count 0->1 in that cycle; after 1650*750 cycles, position returns to (0,0).
- Small-parameter instance (ACTIVE_H=4, H_FP=1, H_SYNC=1, H_BP=1, ACTIVE_V=2, V_FP/V_SYNC/V_BP=1, FC_WIDTH=2), run 5 frames -> frame_count sequence 1,2,3,0,1; new_frame count = 5.
- Assert i_rst_n at hcount=700, vcount=300 -> all outputs 0 asynchronously (before next edge); after release, the sequence restarts at (0,0) and frame_count=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared 1280x720p60 raster timing constants
package video_timing_pkg;
   localparam int ACTIVE_H = 1280;
   localparam int H_FP     = 110;
   localparam int H_SYNC   = 40;
   localparam int H_BP     = 220;
   localparam int ACTIVE_V = 720;
   localparam int V_FP     = 5;
   localparam int V_SYNC   = 5;
   localparam int V_BP     = 20;
   localparam int H_TOTAL  = ACTIVE_H + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = ACTIVE_V + V_FP + V_SYNC + V_BP;
endpackage

// File: rtl/video_sig_gen_wrap_counter.sv
// wrap_counter: modulo-MAX counter with carry-out on wrap
module wrap_counter #(
   parameter  int MAX = 4,
   localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count,
   output logic         o_wrap
);
   localparam logic [W-1:0] LAST = W'(MAX - 1);
   logic [W-1:0] count_q, count_d;
   // out-of-range values fall back to 0 regardless of i_inc
   always_comb begin
      o_wrap  = i_inc && count_q == LAST;
      count_d = count_q > LAST ? '0 : !i_inc ? count_q : o_wrap ? '0 : count_q + 1'b1;
   end
   // count register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) count_q <= '0;
      else          count_q <= count_d;
   assign o_count = count_q;
endmodule

// File: rtl/video_sig_gen.sv
// video_sig_gen: raster timing generator (coordinates, syncs, active, frame strobe/count)
module video_sig_gen #(
   parameter  int ACTIVE_H = video_timing_pkg::ACTIVE_H,
   parameter  int H_FP     = video_timing_pkg::H_FP,
   parameter  int H_SYNC   = video_timing_pkg::H_SYNC,
   parameter  int H_BP     = video_timing_pkg::H_BP,
   parameter  int ACTIVE_V = video_timing_pkg::ACTIVE_V,
   parameter  int V_FP     = video_timing_pkg::V_FP,
   parameter  int V_SYNC   = video_timing_pkg::V_SYNC,
   parameter  int V_BP     = video_timing_pkg::V_BP,
   parameter  int FC_WIDTH = 6,
   localparam int H_TOTAL  = ACTIVE_H + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = ACTIVE_V + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   output logic [HW-1:0]       o_hcount,
   output logic [VW-1:0]       o_vcount,
   output logic                o_hsync,
   output logic                o_vsync,
   output logic                o_active_draw,
   output logic                o_new_frame,
   output logic [FC_WIDTH-1:0] o_frame_count
);
   // counters run one pixel ahead; every output is registered from them together
   logic [HW-1:0] h_cnt, hcount_q, hcount_d;
   logic [VW-1:0] v_cnt, vcount_q, vcount_d;
   logic h_wrap, v_wrap;
   logic hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d, new_frame_q, new_frame_d;
   logic [FC_WIDTH-1:0] fc_q, fc_d;

   wrap_counter #(.MAX(H_TOTAL)) u_h (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(1'b1), .o_count(h_cnt), .o_wrap(h_wrap)
   );
   wrap_counter #(.MAX(V_TOTAL)) u_v (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(h_wrap), .o_count(v_cnt), .o_wrap(v_wrap)
   );

   // decode the upcoming position into its timing flags
   always_comb begin
      hcount_d    = h_cnt;
      vcount_d    = v_cnt;
      active_d    = 32'(h_cnt) < ACTIVE_H && 32'(v_cnt) < ACTIVE_V;
      hsync_d     = 32'(h_cnt) >= ACTIVE_H + H_FP && 32'(h_cnt) < ACTIVE_H + H_FP + H_SYNC;
      vsync_d     = 32'(v_cnt) >= ACTIVE_V + V_FP && 32'(v_cnt) < ACTIVE_V + V_FP + V_SYNC;
      new_frame_d = 32'(h_cnt) == ACTIVE_H && 32'(v_cnt) == ACTIVE_V;
      fc_d        = fc_q + FC_WIDTH'(new_frame_d);
   end

   // output registers, all updated on the same edge
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         hcount_q    <= '0;
         vcount_q    <= '0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         active_q    <= 1'b0;
         new_frame_q <= 1'b0;
         fc_q        <= '0;
      end else begin
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         active_q    <= active_d;
         new_frame_q <= new_frame_d;
         fc_q        <= fc_d;
      end

   a_v_wrap_on_h_wrap: assert property (@(posedge i_clk) disable iff (!i_rst_n) v_wrap |-> h_wrap);

   assign o_hcount      = hcount_q;
   assign o_vcount      = vcount_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_active_draw = active_q;
   assign o_new_frame   = new_frame_q;
   assign o_frame_count = fc_q;
endmodule
